// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO read-side stream adapter: buffer occupancy
// encodings and the read-issue credit rule.
package fifo_stream_reader_pkg;

    localparam int unsigned BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    // A new read may only be issued if every word already committed (buffered
    // or still returning from the FIFO) plus this one fits once this cycle's pop retires.
    function automatic logic can_issue(input occ_e occ, input logic inflight, input logic pop);
        logic [2:0] committed;
        logic [2:0] limit;
        committed = {1'b0, occ} + {2'b00, inflight};
        limit     = 3'(BUF_DEPTH) + {2'b00, pop};
        return committed < limit;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order output buffer presenting FIFO words as a valid/ready stream.
// The head entry always drives the stream; the tail only holds a word while the head stalls.
module fifo_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output occ_e             occ_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    occ_e             state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push_i) begin
                        head_d  = push_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    case ({push_i, pop_i})
                        2'b10: begin
                            tail_d  = push_data_i;
                            state_d = TWO;
                        end
                        2'b01: state_d = EMPTY;
                        2'b11: head_d = push_data_i;
                        default: ;
                    endcase
                end
                TWO: begin
                    // The issue logic never pushes into a full buffer unless it is also popping.
                    if (pop_i) begin
                        head_d = tail_q;
                        if (push_i) begin
                            tail_d = push_data_i;
                        end else begin
                            state_d = ONE;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign occ_o   = state_q;
    assign valid_o = (state_q != EMPTY);
    assign data_o  = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port (one-cycle read latency) into a valid/ready stream,
// with flush, a delivered-word counter and a registered low-water flag.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic             fifo_almost_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_en,
    input  logic             flush,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             low_water
);

    occ_e             occ;
    logic             pop;
    logic             push;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             low_water_q, low_water_d;

    // A word returning during a flush cycle is dropped; no read is issued during
    // flush, so nothing can return in the cycle after it either.
    always_comb begin
        pop         = m_valid & m_ready;
        push        = inflight_q & ~flush;
        fifo_en     = rst & ~fifo_empty & ~flush & can_issue(occ, inflight_q, pop);
        inflight_d  = fifo_en;
        rd_cnt_d    = rd_cnt_q + CNT_W'(pop);
        low_water_d = fifo_almost_empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q  <= 1'b0;
            rd_cnt_q    <= '0;
            low_water_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            rd_cnt_q    <= rd_cnt_d;
            low_water_q <= low_water_d;
        end
    end

    fifo_skid_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(fifo_dout),
        .pop_i      (pop),
        .flush_i    (flush),
        .occ_o      (occ),
        .valid_o    (m_valid),
        .data_o     (m_data)
    );

    assign rd_cnt    = rd_cnt_q;
    assign low_water = low_water_q;

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter CNT_W, default 16, width of delivered-word counter.
REQ-003 clk  input  1  single clock; connects to the FIFO read-side clock (clkb).
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 fifo_empty  input  1  FIFO empty flag, clk domain.
REQ-006 fifo_almost_empty  input  1  FIFO almost-empty flag; status passthrough only.
REQ-007 fifo_dout  input  WIDTH  FIFO read data; valid exactly one cycle after an accepted read.
REQ-008 fifo_en  output  1  FIFO read enable; connects to enb.
REQ-009 flush  input  1  synchronous discard of buffered and in-flight words.
REQ-010 m_valid  output  1  stream data valid.
REQ-011 m_data  output  WIDTH  stream data.
REQ-012 m_ready  input  1  stream consumer ready.
REQ-013 rd_cnt  output  CNT_W  words delivered (m_valid & m_ready) since reset.
REQ-014 low_water  output  1  registered copy of fifo_almost_empty.

Function
REQ-015 Block SHALL drain the FIFO read port into a 2-entry output buffer presented as a valid/ready stream.
REQ-016 A read SHALL be accepted in cycle N iff fifo_en=1 and fifo_empty=0; fifo_dout SHALL be captured in cycle N+1.
REQ-017 fifo_en SHALL never be asserted while fifo_empty=1 or flush=1.
REQ-018 inflight SHALL be a 1-bit register = accepted read in the previous cycle.
REQ-019 fifo_en SHALL = ~fifo_empty & ~flush & ((occ + inflight) < (2 + pop)), where pop = m_valid & m_ready (combinational m_ready->fifo_en path permitted).
REQ-020 Occupancy states EMPTY(0), ONE(1), TWO(2); next occ = occ + inflight - pop; occ SHALL never exceed 2 nor underflow.
REQ-021 m_valid SHALL = (occ != EMPTY); m_data SHALL be the oldest buffered word; order SHALL equal FIFO read order.
REQ-022 Simultaneous push (inflight) and pop in state ONE SHALL remain ONE with new word at head; in TWO, pop and push SHALL keep TWO.
REQ-023 With m_ready held 1 and FIFO non-empty, sustained throughput SHALL be 1 word/cycle; first m_valid SHALL rise 2 cycles after fifo_empty falls.
REQ-024 m_valid/m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-025 flush=1 SHALL set occ to EMPTY next cycle and discard any word returning from an in-flight read that cycle or the next; rd_cnt SHALL not change due to flush.
REQ-026 A pop coincident with flush SHALL count in rd_cnt.
REQ-027 rd_cnt SHALL increment by 1 per pop and wrap modulo 2^CNT_W.

Reset
REQ-028 On rst=0: occ=EMPTY, inflight=0, m_valid=0, m_data=0, fifo_en=0, rd_cnt=0, low_water=0, asynchronously.
REQ-029 Reset mid-operation SHALL drop buffered words; FIFO pointer state is owned by the FIFO and SHALL not be restored.

Structure
REQ-030 Occupancy state encodings (EMPTY/ONE/TWO) SHALL reside in the shared FIFO package; WIDTH/CNT_W stay module parameters.
REQ-031 The 2-entry buffer SHALL be a sub-module named fifo_skid_buf; issue logic, inflight, flush and rd_cnt reside in the top.

Verification
REQ-032 FIFO preloaded with 0x10..0x17, m_ready=1 -> m_data 0x10..0x17 on 8 consecutive cycles, first valid 2 cycles after release, rd_cnt=8.
REQ-033 m_ready=0 with FIFO holding 5 words -> exactly 2 reads accepted, occ=TWO, m_data=first word held; m_ready=1 -> remaining 5 words in order, no loss.
REQ-034 fifo_empty=1 for 10 cycles -> fifo_en=0 throughout, m_valid=0.
REQ-035 flush pulse while occ=TWO and inflight=1 -> m_valid=0 next cycle, returning word discarded, rd_cnt unchanged, next output is the following FIFO word.
REQ-036 CNT_W=4, 17 pops -> rd_cnt=1.
REQ-037 rst asserted mid-stream with occ=ONE -> all outputs 0 immediately; after release streaming resumes from the FIFO head.
